// File: rtl/marche_isa_pkg.sv
// Shared ISA constants and sequencer state encoding for the vector core.
// Opcode occupies instr[0:5]; bit 0 of an instruction word is its MSB.
package marche_isa_pkg;

  localparam int OPC_W  = 6;
  localparam int OPC_HI = 0;
  localparam int OPC_LO = 5;

  localparam logic [OPC_W-1:0] OP_NOP = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LD  = 6'b000001;
  localparam logic [OPC_W-1:0] OP_ST  = 6'b000010;
  localparam logic [OPC_W-1:0] OP_ALU = 6'b000100;
  localparam logic [OPC_W-1:0] OP_VMV = 6'b001000;

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_FETCH    = 3'd1,
    SEQ_ISSUE    = 3'd2,
    SEQ_MEM_WAIT = 3'd3,
    SEQ_DONE     = 3'd4
  } seq_state_e;

  function automatic logic op_known(input logic [OPC_W-1:0] op);
    return (op == OP_NOP) || (op == OP_LD) || (op == OP_ST) ||
           (op == OP_ALU) || (op == OP_VMV);
  endfunction

  function automatic logic op_is_mem(input logic [OPC_W-1:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic op_writes(input logic [OPC_W-1:0] op);
    return (op == OP_ALU) || (op == OP_VMV);
  endfunction

endpackage

// File: rtl/issue_perf_cnt.sv
// Pair of saturating 32-bit event counters with synchronous clear.
module issue_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc_a,
  input  logic        inc_b,
  output logic [31:0] cnt_a,
  output logic [31:0] cnt_b
);

  logic [31:0] cnt_a_q, cnt_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (clr) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (inc_a && !(&cnt_a_q)) cnt_a_q <= cnt_a_q + 32'd1;
      if (inc_b && !(&cnt_b_q)) cnt_b_q <= cnt_b_q + 32'd1;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;

endmodule

// File: rtl/instr_issue_seq.sv
// In-order fetch/issue sequencer: imem fetch, one-cycle issue, LD/ST ack wait with timeout.
// Optional ISSUE_PERF_EN adds perf_issued/perf_stall saturating counters.
module instr_issue_seq
  import marche_isa_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int PROG_LEN = 256,
  parameter int MEM_TO   = 15,
  parameter int TO_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [0:31]     imem_rdata,
  input  logic            imem_valid,
  output logic [0:31]     instr,
  output logic            instr_valid,
  output logic            dmem_req,
  input  logic            dmem_ack,
  output logic            wb_en,
  output logic            busy,
  output logic            done,
  output logic            mem_err,
  output logic            illegal_op
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
`endif
);

  seq_state_e       state_q;
  logic [PC_W-1:0]  pc_q;
  logic [0:31]      instr_q;
  logic [TO_W-1:0]  timer_q;
  logic             mem_err_q;

  logic [OPC_W-1:0] op;
  logic             pc_last;
  logic [PC_W-1:0]  pc_adv_d;
  seq_state_e       st_adv_d;
  logic             start_acc;

  assign op        = instr_q[OPC_HI:OPC_LO];
  assign pc_last   = (pc_q == PC_W'(PROG_LEN - 1));
  assign pc_adv_d  = pc_last ? pc_q : pc_q + 1'b1;
  assign st_adv_d  = pc_last ? SEQ_DONE : SEQ_FETCH;
  assign start_acc = start && ((state_q == SEQ_IDLE) || (state_q == SEQ_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEQ_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      timer_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        SEQ_IDLE, SEQ_DONE: begin
          if (start) begin
            pc_q      <= '0;
            mem_err_q <= 1'b0;
            state_q   <= SEQ_FETCH;
          end
        end
        SEQ_FETCH: begin
          if (imem_valid) begin
            instr_q <= imem_rdata;
            state_q <= SEQ_ISSUE;
          end
        end
        SEQ_ISSUE: begin
          timer_q <= '0;
          if (op_is_mem(op)) begin
            state_q <= SEQ_MEM_WAIT;
          end else begin
            pc_q    <= pc_adv_d;
            state_q <= st_adv_d;
          end
        end
        SEQ_MEM_WAIT: begin
          // An ack arriving in the final timeout cycle still completes normally.
          if (dmem_ack) begin
            pc_q    <= pc_adv_d;
            state_q <= st_adv_d;
          end else if (timer_q == TO_W'(MEM_TO - 1)) begin
            mem_err_q <= 1'b1;
            state_q   <= SEQ_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

  assign imem_req    = (state_q == SEQ_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == SEQ_ISSUE);
  assign illegal_op  = (state_q == SEQ_ISSUE) && !op_known(op);
  assign dmem_req    = ((state_q == SEQ_ISSUE) && op_is_mem(op)) || (state_q == SEQ_MEM_WAIT);
  assign wb_en       = ((state_q == SEQ_ISSUE) && op_writes(op)) ||
                       ((state_q == SEQ_MEM_WAIT) && dmem_ack && (op == OP_LD));
  assign busy        = (state_q != SEQ_IDLE) && (state_q != SEQ_DONE);
  assign done        = (state_q == SEQ_DONE);
  assign mem_err     = mem_err_q;

`ifdef ISSUE_PERF_EN
  issue_perf_cnt u_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .inc_a (instr_valid),
    .inc_b ((state_q == SEQ_FETCH) || (state_q == SEQ_MEM_WAIT)),
    .cnt_a (perf_issued),
    .cnt_b (perf_stall)
  );
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_instr_issue_seq.sv
// Bench for instr_issue_seq (PROG_LEN=4): vector table, random programs vs model, reset abort.
module tb_instr_issue_seq;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        imem_req, imem_valid = 1'b0, instr_valid, dmem_req, dmem_ack = 1'b0;
  logic        wb_en, busy, done, mem_err, illegal_op;
  logic [7:0]  imem_addr;
  logic [0:31] imem_rdata = '0, instr;
`ifdef ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  always #5 clk = ~clk;

  instr_issue_seq #(.PC_W(8), .PROG_LEN(4), .MEM_TO(15), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .instr(instr), .instr_valid(instr_valid),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .wb_en(wb_en), .busy(busy),
    .done(done), .mem_err(mem_err), .illegal_op(illegal_op)
`ifdef ISSUE_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  typedef struct { int iss; int wb; int ill; bit err; int req; } exp_t;
  typedef struct { logic [3:0][31:0] p; int al; int cyc; exp_t e; } vec_t;

  int tests = 0, fails = 0;
  logic [3:0][31:0] prog;
  int ack_lat = 0, fmax = 0;
  bit spur = 1'b0;
  int fcnt = 0, fdel = 0, dcnt = 0;
  logic [31:0] iss_q[$];
  int wb_cnt = 0, ill_cnt = 0, req_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // imem responder: valid after a random 0..fmax cycle delay, 0 = same cycle
  always @(posedge clk) begin
    #1;
    if (imem_req && !imem_valid) begin
      if (fcnt >= fdel) begin
        imem_valid = 1'b1;
        imem_rdata = prog[imem_addr[1:0]];
      end else fcnt++;
    end else begin
      imem_valid = 1'b0;
      fcnt = 0;
      fdel = $urandom_range(0, fmax);
    end
  end

  // dmem responder: ack on the ack_lat-th cycle of dmem_req (0 = never)
  always @(posedge clk) begin
    #1;
    dmem_ack = 1'b0;
    if (dmem_req) begin
      dcnt++;
      if (ack_lat > 0 && dcnt == ack_lat) dmem_ack = 1'b1;
    end else begin
      dcnt = 0;
      if (spur && imem_req) dmem_ack = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (instr_valid) iss_q.push_back(instr);
    if (wb_en) wb_cnt++;
    if (illegal_op) ill_cnt++;
    if (dmem_req) req_cyc++;
  end

  // Program-level expectation: walk the instruction list, stop at the first timed-out mem op.
  function automatic exp_t model(input logic [3:0][31:0] p, input int al);
    exp_t e = '{0, 0, 0, 1'b0, 0};
    for (int i = 0; i < 4; i++) begin
      logic [5:0] op = p[i][31:26];
      e.iss++;
      case (op)
        6'd1, 6'd2: begin
          if (al < 2 || al > 16) begin e.err = 1'b1; e.req += 16; return e; end
          e.req += al;
          if (op == 6'd1) e.wb++;
        end
        6'd4, 6'd8: e.wb++;
        6'd0: ;
        default: e.ill++;
      endcase
    end
    return e;
  endfunction

  function automatic logic [3:0][31:0] p4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic run(input string tag, input logic [3:0][31:0] p, input int al,
                     input int cyc_exp, input exp_t e);
    int n = 0;
    prog = p; ack_lat = al;
    @(negedge clk);
    iss_q.delete(); wb_cnt = 0; ill_cnt = 0; req_cyc = 0;
    start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 1) begin
        chk({tag, " mem_err_clr"}, 64'(mem_err), 64'd0);
        chk({tag, " addr0"}, 64'(imem_addr), 64'd0);
      end
    end while (!done && n < 300);
    chk({tag, " done"}, 64'(done), 64'd1);
    if (cyc_exp > 0) chk({tag, " cycles"}, 64'(n), 64'(cyc_exp));
    chk({tag, " issued"}, 64'(iss_q.size()), 64'(e.iss));
    for (int i = 0; i < iss_q.size() && i < e.iss; i++)
      chk({tag, " order"}, 64'(iss_q[i]), 64'(p[i]));
    chk({tag, " wb"}, 64'(wb_cnt), 64'(e.wb));
    chk({tag, " illegal"}, 64'(ill_cnt), 64'(e.ill));
    chk({tag, " mem_err"}, 64'(mem_err), 64'(e.err));
    chk({tag, " req_cyc"}, 64'(req_cyc), 64'(e.req));
    chk({tag, " instr_hold"}, 64'(instr), 64'(p[e.iss-1]));
    chk({tag, " busy"}, 64'(busy), 64'd0);
`ifdef ISSUE_PERF_EN
    chk({tag, " perf_issued"}, 64'(perf_issued), 64'(e.iss));
`endif
  endtask

  localparam logic [31:0] ALU = 32'h11AA5800, LD = 32'h05A00001, ST = 32'h09A00001;
  localparam logic [31:0] NOP = 32'h01AA5D8B, ILL = 32'hFC000000, VMV = 32'h21000000;

  initial begin
    vec_t vecs[6];
    logic [5:0] opts[6];
    vecs[0] = '{p4(ALU, ALU, ALU, ALU), 0,  9, '{4, 4, 0, 1'b0, 0}};
    vecs[1] = '{p4(LD, ALU, ALU, ALU),  3, 11, '{4, 4, 0, 1'b0, 3}};
    vecs[2] = '{p4(ST, ALU, ALU, ALU),  3, 11, '{4, 3, 0, 1'b0, 3}};
    vecs[3] = '{p4(LD, ALU, ALU, ALU),  0, 18, '{1, 0, 0, 1'b1, 16}};
    vecs[4] = '{p4(LD, ALU, ALU, ALU), 16, 24, '{4, 4, 0, 1'b0, 16}};
    vecs[5] = '{p4(ILL, NOP, VMV, ALU), 0,  9, '{4, 2, 1, 1'b0, 0}};

    repeat (2) @(negedge clk);
    chk("rst imem_req", 64'(imem_req), 0);
    chk("rst instr", 64'(instr), 0);
    chk("rst flags", 64'({instr_valid, dmem_req, wb_en, busy, done, mem_err, illegal_op}), 0);
    chk("rst addr", 64'(imem_addr), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run($sformatf("vec%0d", i), vecs[i].p, vecs[i].al, vecs[i].cyc, vecs[i].e);

    // abort in MEM_WAIT: async reset drops requests at once
    prog = p4(LD, ALU, ALU, ALU); ack_lat = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-rst dmem_req", 64'(dmem_req), 1);
    rst_n = 1'b0;
    #1;
    chk("rst dmem_req", 64'(dmem_req), 0);
    chk("rst instr0", 64'(instr), 0);
    chk("rst busy", 64'(busy), 0);
    chk("rst imem_req0", 64'(imem_req), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run("restart", p4(ALU, VMV, NOP, ALU), 0, 9, '{4, 3, 0, 1'b0, 0});

    opts = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd8, 6'd0};
    fmax = 4; spur = 1'b1;
    for (int r = 0; r < 20; r++) begin
      logic [3:0][31:0] p;
      int al, sel;
      for (int i = 0; i < 4; i++) begin
        logic [5:0] op;
        sel = $urandom_range(0, 5);
        op = (sel == 5) ? 6'($urandom_range(16, 63)) : opts[sel];
        p[i] = {op, 26'($urandom)};
      end
      sel = $urandom_range(0, 6);
      al = (sel == 6) ? 0 : (sel == 5) ? 16 : sel + 2;
      run($sformatf("rnd%0d", r), p, al, 0, model(p, al));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
